// File: rtl/rc5_pkg.sv
// rc5_pkg: shared RC5 types, magic constants and a width-generic left-rotate helper
package rc5_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, READ, MIX_S, MIX_L, WRITE, DONE} state_t;
  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
  localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;
  function automatic logic [63:0] rotl(input logic [63:0] x, input logic [5:0] amt, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((x << amt) | ((x & m) >> (w - int'(amt)))) & m;
  endfunction
endpackage

// File: rtl/rc5_key_mix_if.sv
// rc5_key_mix_if: start/status plus S and L RAM ports; master = controller side, slave = rc5_key_mix
interface rc5_key_mix_if #(parameter int W = 32, parameter int TL = 5, parameter int CL = 2);
  logic          start;
  logic [TL-1:0] S_address;
  logic [W-1:0]  S_sub_i;
  logic [W-1:0]  S_sub_i_prima;
  logic          S_we;
  logic [CL-1:0] L_address;
  logic [W-1:0]  L_sub_i;
  logic [W-1:0]  L_sub_i_prima;
  logic          L_we;
  logic          busy;
  logic          done;
  modport master (output start, S_sub_i, L_sub_i,
                  input S_address, S_sub_i_prima, S_we, L_address, L_sub_i_prima, L_we, busy, done);
  modport slave  (input start, S_sub_i, L_sub_i,
                  output S_address, S_sub_i_prima, S_we, L_address, L_sub_i_prima, L_we, busy, done);
endinterface

// File: rtl/rc5_rotl.sv
// rc5_rotl: combinational barrel left-rotate; x rotated left by amt (RW bits) onto y
module rc5_rotl #(
  parameter int W  = 32,
  parameter int RW = $clog2(W)
) (
  input  logic [W-1:0]  x,
  input  logic [RW-1:0] amt,
  output logic [W-1:0]  y
);
  assign y = W'(({x, x} << amt) >> W);
endmodule

// File: rtl/rc5_key_mix.sv
// rc5_key_mix: RC5 key-schedule mixing FSM; ports clk, rst (sync high), bus (start/busy/done, S and L RAM address/read/write/we)
module rc5_key_mix
  import rc5_pkg::*;
#(
  parameter int B = 16,
  parameter int W = 32,
  parameter int R = 12
) (
  input logic          clk,
  input logic          rst,
  rc5_key_mix_if.slave bus
);
  localparam int U = W / 8;
  localparam int C = B / U;
  localparam int T = 2 * R + 2;
  localparam int N = 3 * ((T > C) ? T : C);
  localparam int C_length = $clog2(C);
  localparam int T_length = $clog2(T);
  localparam int N_length = $clog2(N + 1);
  localparam int RW = $clog2(W);
  localparam logic [T_length-1:0] I_LAST = T_length'(T - 1);
  localparam logic [C_length-1:0] J_LAST = C_length'(C - 1);
  localparam logic [N_length-1:0] K_LAST = N_length'(N - 1);
  state_t state, state_n;
  logic [W-1:0] a_r, a_n, b_r, b_n, s_val, s_val_n, l_val, l_val_n;
  logic [W-1:0] s_wd, s_wd_n, l_wd, l_wd_n, ab, rot3, rotv;
  logic [T_length-1:0] i_r, i_n;
  logic [C_length-1:0] j_r, j_n;
  logic [N_length-1:0] k_r, k_n;
  logic s_we, l_we, busy, done;
  assign ab = a_r + b_r;
  rc5_rotl #(.W(W), .RW(RW)) u_rot3 (.x(s_val + ab), .amt(RW'(3)), .y(rot3));
  rc5_rotl #(.W(W), .RW(RW)) u_rotv (.x(l_val + ab), .amt(ab[RW-1:0]), .y(rotv));
  always_comb begin
    state_n = state;
    a_n     = a_r;
    b_n     = b_r;
    i_n     = i_r;
    j_n     = j_r;
    k_n     = k_r;
    s_val_n = s_val;
    l_val_n = l_val;
    s_wd_n  = s_wd;
    l_wd_n  = l_wd;
    unique case (state)
      IDLE, DONE: if (bus.start) begin
        state_n = ADDR;
        a_n     = '0;
        b_n     = '0;
        i_n     = '0;
        j_n     = '0;
        k_n     = '0;
      end
      ADDR: state_n = READ;
      READ: begin
        state_n = MIX_S;
        s_val_n = bus.S_sub_i;
        l_val_n = bus.L_sub_i;
      end
      MIX_S: begin
        state_n = MIX_L;
        a_n     = rot3;
        s_wd_n  = rot3;
      end
      MIX_L: begin
        state_n = WRITE;
        b_n     = rotv;
        l_wd_n  = rotv;
      end
      WRITE: begin
        state_n = (k_r == K_LAST) ? DONE : ADDR;
        k_n     = k_r + 1'b1;
        i_n     = (i_r == I_LAST) ? '0 : i_r + 1'b1;
        j_n     = (j_r == J_LAST) ? '0 : j_r + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      i_r   <= '0;
      j_r   <= '0;
      k_r   <= '0;
      s_val <= '0;
      l_val <= '0;
      s_wd  <= '0;
      l_wd  <= '0;
      s_we  <= 1'b0;
      l_we  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a_r   <= a_n;
      b_r   <= b_n;
      i_r   <= i_n;
      j_r   <= j_n;
      k_r   <= k_n;
      s_val <= s_val_n;
      l_val <= l_val_n;
      s_wd  <= s_wd_n;
      l_wd  <= l_wd_n;
      s_we  <= state_n == MIX_L;
      l_we  <= state_n == WRITE;
      busy  <= state_n inside {ADDR, READ, MIX_S, MIX_L, WRITE};
      done  <= state_n == DONE;
    end
  end
  assign bus.S_address     = i_r;
  assign bus.L_address     = j_r;
  assign bus.S_sub_i_prima = s_wd;
  assign bus.L_sub_i_prima = l_wd;
  assign bus.S_we          = s_we;
  assign bus.L_we          = l_we;
  assign bus.busy          = busy;
  assign bus.done          = done;
endmodule

// File: tb/tb_rc5_key_mix.sv
// tb_rc5_key_mix: scoreboard bench for rc5_key_mix with behavioural S/L RAMs and a software RC5-32/12/16 mixing model
module tb_rc5_key_mix;
  import rc5_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rc5_key_mix_if #(.W(32), .TL(5), .CL(2)) bus ();
  rc5_key_mix #(.B(16), .W(32), .R(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] s_mem [26];
  logic [31:0] l_mem [4];
  logic [31:0] s_init [26];
  logic [31:0] l_init [4];
  logic [31:0] exp_s [26];
  logic [31:0] exp_l [4];
  logic load = 1'b0;
  logic [36:0] s_q [$];
  logic [33:0] l_q [$];
  logic [36:0] first_s, se;
  logic [33:0] first_l, le;
  int compared = 0;
  int mismatched = 0;
  int s_cnt = 0;
  int l_cnt = 0;
  int overlap = 0;
  always @(posedge clk) begin
    if (load) begin
      s_mem <= s_init;
      l_mem <= l_init;
    end else begin
      if (bus.S_we) s_mem[bus.S_address] <= bus.S_sub_i_prima;
      if (bus.L_we) l_mem[bus.L_address] <= bus.L_sub_i_prima;
    end
    bus.S_sub_i <= s_mem[bus.S_address];
    bus.L_sub_i <= l_mem[bus.L_address];
  end
  always @(negedge clk) begin
    if (bus.S_we && bus.L_we) overlap++;
    if (bus.S_we) begin
      if (s_cnt == 0) first_s = {bus.S_address, bus.S_sub_i_prima};
      s_cnt++;
      compared++;
      if (s_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_s_write: got %h want no write", {bus.S_address, bus.S_sub_i_prima});
      end else begin
        se = s_q.pop_front();
        if ({bus.S_address, bus.S_sub_i_prima} !== se) begin
          mismatched++;
          $display("FAIL sb_s_write #%0d: got addr/data %h want %h", s_cnt, {bus.S_address, bus.S_sub_i_prima}, se);
        end
      end
    end
    if (bus.L_we) begin
      if (l_cnt == 0) first_l = {bus.L_address, bus.L_sub_i_prima};
      l_cnt++;
      compared++;
      if (l_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_l_write: got %h want no write", {bus.L_address, bus.L_sub_i_prima});
      end else begin
        le = l_q.pop_front();
        if ({bus.L_address, bus.L_sub_i_prima} !== le) begin
          mismatched++;
          $display("FAIL sb_l_write #%0d: got addr/data %h want %h", l_cnt, {bus.L_address, bus.L_sub_i_prima}, le);
        end
      end
    end
  end
  function automatic logic [31:0] rl(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction
  task automatic load_mem();
    for (int n = 0; n < 26; n++) s_init[n] = P32 + Q32 * n;
    for (int n = 0; n < 4; n++) l_init[n] = '0;
    @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask
  task automatic model_push();
    logic [31:0] a, b;
    int i, j;
    a = '0;
    b = '0;
    i = 0;
    j = 0;
    exp_s = s_init;
    exp_l = l_init;
    s_q.delete();
    l_q.delete();
    s_cnt = 0;
    l_cnt = 0;
    overlap = 0;
    for (int k = 0; k < 78; k++) begin
      a = rl(exp_s[i] + a + b, 5'd3);
      exp_s[i] = a;
      s_q.push_back({5'(i), a});
      b = rl(exp_l[j] + a + b, 5'(a + b));
      exp_l[j] = b;
      l_q.push_back({2'(j), b});
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask
  task automatic do_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic run_cycles(input int max_cyc, input int rst_at, input int p1, input int p2,
                            output int done_cyc, output int busy_cnt, output logic d1);
    done_cyc = 0;
    busy_cnt = 0;
    d1 = 1'bx;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (cyc == 1) d1 = bus.done;
      if (bus.busy) busy_cnt++;
      if (bus.done && done_cyc == 0) done_cyc = cyc;
      bus.start = (cyc == p1) || (cyc == p2);
      if (cyc == rst_at) rst = 1'b1;
    end
    bus.start = 1'b0;
  endtask
  task automatic check_full_run(input string tag, input int done_cyc, input int busy_cnt);
    compared += 7;
    if (done_cyc !== 391) begin mismatched++; $display("FAIL %s done_cycle: got %0d want 391", tag, done_cyc); end
    if (busy_cnt !== 390) begin mismatched++; $display("FAIL %s busy_cycles: got %0d want 390", tag, busy_cnt); end
    if (s_cnt !== 78) begin mismatched++; $display("FAIL %s s_we_pulses: got %0d want 78", tag, s_cnt); end
    if (l_cnt !== 78) begin mismatched++; $display("FAIL %s l_we_pulses: got %0d want 78", tag, l_cnt); end
    if (overlap !== 0) begin mismatched++; $display("FAIL %s we_overlap: got %0d want 0", tag, overlap); end
    if (first_s !== {5'd0, 32'hBF0A8B1D}) begin mismatched++; $display("FAIL %s first_s: got %h want %h", tag, first_s, {5'd0, 32'hBF0A8B1D}); end
    if (first_l !== {2'd0, 32'hB7E15163}) begin mismatched++; $display("FAIL %s first_l: got %h want %h", tag, first_l, {2'd0, 32'hB7E15163}); end
    for (int n = 0; n < 26; n++) begin
      compared++;
      if (s_mem[n] !== exp_s[n]) begin mismatched++; $display("FAIL %s s_table[%0d]: got %h want %h", tag, n, s_mem[n], exp_s[n]); end
    end
    for (int n = 0; n < 4; n++) begin
      compared++;
      if (l_mem[n] !== exp_l[n]) begin mismatched++; $display("FAIL %s l_table[%0d]: got %h want %h", tag, n, l_mem[n], exp_l[n]); end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared += 5;
    if (bus.S_address !== 5'd0) begin mismatched++; $display("FAIL reset S_address: got %h want 0", bus.S_address); end
    if (bus.L_address !== 2'd0) begin mismatched++; $display("FAIL reset L_address: got %h want 0", bus.L_address); end
    if (bus.S_sub_i_prima !== 32'd0) begin mismatched++; $display("FAIL reset S_sub_i_prima: got %h want 0", bus.S_sub_i_prima); end
    if (bus.L_sub_i_prima !== 32'd0) begin mismatched++; $display("FAIL reset L_sub_i_prima: got %h want 0", bus.L_sub_i_prima); end
    if ({bus.S_we, bus.L_we, bus.busy, bus.done} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset ctrl: got %b want 0000", {bus.S_we, bus.L_we, bus.busy, bus.done});
    end
    rst = 1'b0;
  endtask
  task automatic test_zero_key();
    int dc, bc;
    logic d1;
    load_mem();
    model_push();
    do_start();
    run_cycles(400, 0, 0, 0, dc, bc, d1);
    check_full_run("zero_key", dc, bc);
    compared += 2;
    if (s_q.size() !== 0) begin mismatched++; $display("FAIL zero_key s_queue_left: got %0d want 0", s_q.size()); end
    if (l_q.size() !== 0) begin mismatched++; $display("FAIL zero_key l_queue_left: got %0d want 0", l_q.size()); end
  endtask
  task automatic test_start_ignored();
    int dc, bc;
    logic d1;
    load_mem();
    model_push();
    do_start();
    run_cycles(400, 0, 10, 200, dc, bc, d1);
    check_full_run("start_ignored", dc, bc);
  endtask
  task automatic test_reset_mid();
    int dc, bc;
    logic d1;
    load_mem();
    model_push();
    do_start();
    run_cycles(150, 150, 0, 0, dc, bc, d1);
    @(negedge clk);
    compared += 3;
    if ({bus.S_address, bus.L_address} !== 7'd0) begin mismatched++; $display("FAIL rst_mid addr: got %h want 0", {bus.S_address, bus.L_address}); end
    if ({bus.S_sub_i_prima, bus.L_sub_i_prima} !== 64'd0) begin
      mismatched++;
      $display("FAIL rst_mid data: got %h want 0", {bus.S_sub_i_prima, bus.L_sub_i_prima});
    end
    if ({bus.S_we, bus.L_we, bus.busy, bus.done} !== 4'b0) begin
      mismatched++;
      $display("FAIL rst_mid ctrl: got %b want 0000", {bus.S_we, bus.L_we, bus.busy, bus.done});
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    compared += 2;
    if (s_cnt !== 30) begin mismatched++; $display("FAIL rst_mid s_writes: got %0d want 30", s_cnt); end
    if (l_cnt !== 30) begin mismatched++; $display("FAIL rst_mid l_writes: got %0d want 30", l_cnt); end
    load_mem();
    model_push();
    do_start();
    run_cycles(400, 0, 0, 0, dc, bc, d1);
    check_full_run("after_rst", dc, bc);
  endtask
  task automatic test_restart_done();
    int dc, bc;
    logic d1;
    compared++;
    if (bus.done !== 1'b1) begin mismatched++; $display("FAIL restart pre_done: got %b want 1", bus.done); end
    load_mem();
    model_push();
    do_start();
    run_cycles(400, 0, 0, 0, dc, bc, d1);
    compared++;
    if (d1 !== 1'b0) begin mismatched++; $display("FAIL restart done_cleared: got %b want 0", d1); end
    check_full_run("restart", dc, bc);
  endtask
  initial begin
    bus.start = 1'b0;
    test_reset();
    test_zero_key();
    test_start_ignored();
    test_reset_mid();
    test_restart_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
